// File: rtl/pipeline_stall_ctrl.sv
// Stall/flush generator: per-bus IDLE/BUSY/DRAIN trackers feed a prefix-shaped stall vector.
// Optional STALL_PERF_CNT_EN adds stall-cycle and flush counters.
module pipeline_stall_ctrl #(
    parameter int STAGES    = 5,
    parameter int MEM_STAGE = 3
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [STAGES-1:0] stall_req,
    input  logic              if_req,
    input  logic              if_ack,
    input  logic              mem_req,
    input  logic              mem_ack,
    input  logic              flush,
    output logic [STAGES-1:0] stall,
    output logic              flush_out,
    output logic              if_discard,
    output logic              mem_discard
`ifdef STALL_PERF_CNT_EN
    ,
    output logic [31:0]       perf_stall_cycles,
    output logic [15:0]       perf_flush_cnt
`endif
);

    typedef enum logic [1:0] {
        CH_IDLE  = 2'd0,
        CH_BUSY  = 2'd1,
        CH_DRAIN = 2'd2
    } ch_state_e;

    ch_state_e if_state_q, if_state_d;
    ch_state_e mem_state_q, mem_state_d;

    logic              if_wait, mem_wait;
    logic              drain_hold;
    logic [STAGES-1:0] raw;
    logic [STAGES-1:0] prefix;
    logic              acc;

    // An ack in the flush cycle completes the access, so it never enters DRAIN.
    function automatic ch_state_e ch_next(input ch_state_e s, input logic req,
                                          input logic ack, input logic fl);
        ch_state_e n;
        n = s;
        case (s)
            CH_IDLE:  if (req && !ack) n = fl ? CH_DRAIN : CH_BUSY;
            CH_BUSY:  if (ack) n = CH_IDLE; else if (fl) n = CH_DRAIN;
            CH_DRAIN: if (ack) n = CH_IDLE;
            default:  n = CH_IDLE;
        endcase
        return n;
    endfunction

    function automatic logic ch_wait(input ch_state_e s, input logic req, input logic ack);
        return ((s == CH_IDLE) && req && !ack) || ((s == CH_BUSY) && !ack);
    endfunction

    always_ff @(posedge clk) begin
        if (rst) begin
            if_state_q  <= CH_IDLE;
            mem_state_q <= CH_IDLE;
        end else begin
            if_state_q  <= if_state_d;
            mem_state_q <= mem_state_d;
        end
    end

    always_comb begin
        if_state_d  = if_state_q;
        mem_state_d = mem_state_q;
        if_state_d  = ch_next(if_state_q, if_req, if_ack, flush);
        mem_state_d = ch_next(mem_state_q, mem_req, mem_ack, flush);
    end

    always_comb begin
        if_wait     = ch_wait(if_state_q, if_req, if_ack);
        mem_wait    = ch_wait(mem_state_q, mem_req, mem_ack);
        if_discard  = (if_state_q == CH_DRAIN) && if_ack;
        mem_discard = (mem_state_q == CH_DRAIN) && mem_ack;
        flush_out   = flush;
    end

    // A stall in stage j must also freeze every earlier stage.
    always_comb begin
        raw            = stall_req;
        raw[0]         = raw[0] | if_wait;
        raw[MEM_STAGE] = raw[MEM_STAGE] | mem_wait;
        prefix         = '0;
        acc            = 1'b0;
        for (int i = STAGES - 1; i >= 0; i--) begin
            acc       = acc | raw[i];
            prefix[i] = acc;
        end
    end

    always_comb begin
        drain_hold = ((if_state_q == CH_DRAIN) && !if_ack) ||
                     ((mem_state_q == CH_DRAIN) && !mem_ack);
        if (drain_hold) begin
            stall = '1;
        end else if (flush) begin
            stall = '0;
        end else begin
            stall = prefix;
        end
    end

`ifdef STALL_PERF_CNT_EN
    logic [31:0] perf_stall_q;
    logic [15:0] perf_flush_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            perf_stall_q <= 32'd0;
            perf_flush_q <= 16'd0;
        end else begin
            if (stall[0]) perf_stall_q <= perf_stall_q + 32'd1;
            if (flush)    perf_flush_q <= perf_flush_q + 16'd1;
        end
    end

    assign perf_stall_cycles = perf_stall_q;
    assign perf_flush_cnt    = perf_flush_q;
`endif

endmodule

// File: tb/tb_pipeline_stall_ctrl.sv
// Scoreboard bench for pipeline_stall_ctrl: expectations queued at drive time, compared mid-cycle.
module tb_pipeline_stall_ctrl;

    logic       clk;
    logic       rst;
    logic [4:0] stall_req;
    logic       if_req, if_ack, mem_req, mem_ack, flush;
    logic [4:0] stall;
    logic       flush_out, if_discard, mem_discard;
`ifdef STALL_PERF_CNT_EN
    logic [31:0] perf_stall_cycles;
    logic [15:0] perf_flush_cnt;
`endif

    pipeline_stall_ctrl #(.STAGES(5), .MEM_STAGE(3)) dut (
        .clk         (clk),
        .rst         (rst),
        .stall_req   (stall_req),
        .if_req      (if_req),
        .if_ack      (if_ack),
        .mem_req     (mem_req),
        .mem_ack     (mem_ack),
        .flush       (flush),
        .stall       (stall),
        .flush_out   (flush_out),
        .if_discard  (if_discard),
        .mem_discard (mem_discard)
`ifdef STALL_PERF_CNT_EN
        ,
        .perf_stall_cycles (perf_stall_cycles),
        .perf_flush_cnt    (perf_flush_cnt)
`endif
    );

    typedef struct {
        string      tag;
        bit         skip;
        logic [4:0] stall;
        logic       fo;
        logic       ifd;
        logic       md;
        bit         pchk;
        logic [31:0] pc;
        logic [15:0] fc;
    } exp_t;

    exp_t sb_q[$];
    exp_t cur;
    int   checks   = 0;
    int   failures = 0;

    bit          pchk_nxt = 0;
    logic [31:0] pc_nxt   = '0;
    logic [15:0] fc_nxt   = '0;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=0x%0h exp=0x%0h", tag, got, exp);
        end
    endtask

    // One clock of stimulus; expected combinational outputs for that same cycle are queued.
    task automatic cyc(input string tag, input logic r, input logic [4:0] sreq,
                       input logic ifr, input logic ifa, input logic mr, input logic ma,
                       input logic fl, input logic [4:0] es, input logic eifd,
                       input logic emd, input bit skip);
        exp_t e;
        @(posedge clk);
        #1;
        rst       = r;
        stall_req = sreq;
        if_req    = ifr;
        if_ack    = ifa;
        mem_req   = mr;
        mem_ack   = ma;
        flush     = fl;
        e.tag   = tag;
        e.skip  = skip;
        e.stall = es;
        e.fo    = fl;
        e.ifd   = eifd;
        e.md    = emd;
        e.pchk  = pchk_nxt;
        e.pc    = pc_nxt;
        e.fc    = fc_nxt;
        pchk_nxt = 0;
        sb_q.push_back(e);
    endtask

    always @(negedge clk) begin
        if (sb_q.size() != 0) begin
            cur = sb_q.pop_front();
            if (!cur.skip) begin
                check_eq({cur.tag, ".stall"}, 32'(stall), 32'(cur.stall));
                check_eq({cur.tag, ".flush_out"}, 32'(flush_out), 32'(cur.fo));
                check_eq({cur.tag, ".if_discard"}, 32'(if_discard), 32'(cur.ifd));
                check_eq({cur.tag, ".mem_discard"}, 32'(mem_discard), 32'(cur.md));
`ifdef STALL_PERF_CNT_EN
                if (cur.pchk) begin
                    check_eq({cur.tag, ".perf_stall"}, perf_stall_cycles, cur.pc);
                    check_eq({cur.tag, ".perf_flush"}, 32'(perf_flush_cnt), 32'(cur.fc));
                end
`endif
            end
        end
    end

    initial begin
        int guard;
        rst = 1'b1; stall_req = '0;
        if_req = 0; if_ack = 0; mem_req = 0; mem_ack = 0; flush = 0;

        //   tag        rst sreq     ifr ifa mr ma fl  exp_stall ifd md skip
        cyc("reset0",    1, 5'b00000, 0, 0, 0, 0, 0, 5'b00000, 0, 0, 0);
        cyc("reset1",    1, 5'b00000, 0, 0, 0, 0, 0, 5'b00000, 0, 0, 0);

        cyc("sreq_ex0",  0, 5'b00100, 0, 0, 0, 0, 0, 5'b00111, 0, 0, 0);
        cyc("sreq_ex1",  0, 5'b00100, 0, 0, 0, 0, 0, 5'b00111, 0, 0, 0);
        cyc("sreq_off",  0, 5'b00000, 0, 0, 0, 0, 0, 5'b00000, 0, 0, 0);
        cyc("sreq_wb",   0, 5'b10000, 0, 0, 0, 0, 0, 5'b11111, 0, 0, 0);
        cyc("sreq_if",   0, 5'b00001, 0, 0, 0, 0, 0, 5'b00001, 0, 0, 0);

        cyc("mem_c1",    0, 5'b00000, 0, 0, 1, 0, 0, 5'b01111, 0, 0, 0);
        cyc("mem_c2",    0, 5'b00000, 0, 0, 1, 0, 0, 5'b01111, 0, 0, 0);
        cyc("mem_c3",    0, 5'b00000, 0, 0, 1, 0, 0, 5'b01111, 0, 0, 0);
        cyc("mem_ack",   0, 5'b00000, 0, 0, 1, 1, 0, 5'b00000, 0, 0, 0);
        cyc("mem_idle",  0, 5'b00000, 0, 0, 0, 0, 0, 5'b00000, 0, 0, 0);

        cyc("if_hit",    0, 5'b00000, 1, 1, 0, 0, 0, 5'b00000, 0, 0, 0);
        cyc("if_hit_nx", 0, 5'b00000, 0, 0, 0, 0, 0, 5'b00000, 0, 0, 0);
        cyc("if_miss",   0, 5'b00100, 1, 0, 0, 0, 0, 5'b00111, 0, 0, 0);
        cyc("if_ack",    0, 5'b00000, 0, 1, 0, 0, 0, 5'b00000, 0, 0, 0);

        cyc("dm_c1",     0, 5'b00000, 0, 0, 1, 0, 0, 5'b01111, 0, 0, 0);
        cyc("dm_flush",  0, 5'b00000, 0, 0, 0, 0, 1, 5'b00000, 0, 0, 0);
        cyc("dm_c3",     0, 5'b00000, 0, 0, 0, 0, 0, 5'b11111, 0, 0, 0);
        cyc("dm_c4",     0, 5'b00010, 0, 0, 0, 0, 0, 5'b11111, 0, 0, 0);
        cyc("dm_ack",    0, 5'b00000, 0, 0, 0, 1, 0, 5'b00000, 0, 1, 0);
        cyc("dm_after",  0, 5'b00000, 0, 0, 0, 0, 0, 5'b00000, 0, 0, 0);

        cyc("bb_req",    0, 5'b00000, 1, 0, 1, 0, 0, 5'b01111, 0, 0, 0);
        cyc("bb_busy",   0, 5'b00000, 0, 0, 0, 0, 0, 5'b01111, 0, 0, 0);
        cyc("bb_flush",  0, 5'b00000, 0, 0, 0, 0, 1, 5'b00000, 0, 0, 0);
        cyc("bb_p1",     0, 5'b00000, 0, 0, 0, 0, 0, 5'b11111, 0, 0, 0);
        cyc("bb_ifack",  0, 5'b00000, 0, 1, 0, 0, 0, 5'b11111, 1, 0, 0);
        cyc("bb_p3",     0, 5'b00000, 0, 0, 0, 0, 0, 5'b11111, 0, 0, 0);
        cyc("bb_memack", 0, 5'b00000, 0, 0, 0, 1, 0, 5'b00000, 0, 1, 0);
        cyc("bb_after",  0, 5'b00000, 0, 0, 0, 0, 0, 5'b00000, 0, 0, 0);

        cyc("fa_req",    0, 5'b00000, 0, 0, 1, 0, 0, 5'b01111, 0, 0, 0);
        cyc("fa_both",   0, 5'b00000, 0, 0, 0, 1, 1, 5'b00000, 0, 0, 0);
        cyc("fa_after",  0, 5'b00000, 0, 0, 0, 0, 0, 5'b00000, 0, 0, 0);

        cyc("id_flush",  0, 5'b00000, 0, 0, 1, 0, 1, 5'b00000, 0, 0, 0);
        cyc("id_drain",  0, 5'b00000, 0, 0, 0, 0, 0, 5'b11111, 0, 0, 0);
        cyc("id_ack",    0, 5'b00000, 0, 0, 0, 1, 0, 5'b00000, 0, 1, 0);
        cyc("stray_ack", 0, 5'b00000, 0, 1, 0, 1, 0, 5'b00000, 0, 0, 0);

        cyc("rd_req",    0, 5'b00000, 0, 0, 1, 0, 0, 5'b01111, 0, 0, 0);
        cyc("rd_flush",  0, 5'b00000, 0, 0, 0, 0, 1, 5'b00000, 0, 0, 0);
        cyc("rd_drain",  0, 5'b00000, 0, 0, 0, 0, 0, 5'b11111, 0, 0, 0);
        cyc("rd_rst",    1, 5'b00000, 0, 0, 0, 0, 0, 5'b00000, 0, 0, 1);
        pchk_nxt = 1; pc_nxt = 32'd0; fc_nxt = 16'd0;
        cyc("rd_ack",    0, 5'b00000, 0, 0, 0, 1, 0, 5'b00000, 0, 0, 0);
        cyc("rd_idle",   0, 5'b00000, 0, 0, 0, 0, 0, 5'b00000, 0, 0, 0);

        for (int k = 0; k < 3; k++)
            cyc("pc_stall", 0, 5'b00001, 0, 0, 0, 0, 0, 5'b00001, 0, 0, 0);
        pchk_nxt = 1; pc_nxt = 32'd3; fc_nxt = 16'd0;
        cyc("pc_flush",  0, 5'b00000, 0, 0, 0, 0, 1, 5'b00000, 0, 0, 0);
        pchk_nxt = 1; pc_nxt = 32'd3; fc_nxt = 16'd1;
        cyc("pc_final",  0, 5'b00000, 0, 0, 0, 0, 0, 5'b00000, 0, 0, 0);

        guard = 0;
        while (sb_q.size() != 0 && guard < 20) begin
            @(posedge clk);
            guard++;
        end
        check_eq("sb_drain", 32'(sb_q.size()), 32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
